mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus initiator that drives the 16-bit × 1024-word single-port data memory: address, write enable, write data, and the combinational read-data return.
- Performs block copy (read src → write dst) or block fill (write constant) of up to 1024 words.
- Started by the control unit with a one-cycle start; reports busy, remaining count and a done pulse.
- Sits beside the core's load/store path, muxed onto the memory port by the top level.

Parameters:
- ADDR_WIDTH, 10, memory address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, memory word width.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- start  input  1  request pulse, sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; sampled with start
- src_addr  input  ADDR_WIDTH  copy source base; sampled with start
- dst_addr  input  ADDR_WIDTH  destination base; sampled with start
- length  input  ADDR_WIDTH+1  word count 0..1024; sampled with start
- fill_value  input  DATA_WIDTH  fill word; sampled with start
- busy  output  1  high in READ/WRITE
- done  output  1  one-cycle completion pulse
- words_left  output  ADDR_WIDTH+1  words not yet written
- mem_address  output  ADDR_WIDTH  to memory address
- mem_we  output  1  to memory WE
- mem_data_in  output  DATA_WIDTH  to memory write data
- mem_data_out  input  DATA_WIDTH  from memory, combinational read of mem_address

Behaviour:
- Reset (async, RST_N=0): state=IDLE; busy=0, done=0, words_left=0, mem_we=0, mem_address=0, mem_data_in=0, internal pointers/buffer=0. Reset mid-operation aborts immediately. Words already written stay written; no further writes occur.
- States: IDLE, READ, WRITE, DONE.
- IDLE: on edge with start=1, latch mode, pointers, fill_value and count.
  - Count = length, clamped to 1024 if length > 1024.
  - count=0 → DONE.
  - mode=1 → WRITE.
  - Otherwise → READ.
- READ (copy only): mem_address=src_ptr, mem_we=0. At the edge: buffer ← mem_data_out, src_ptr+1, → WRITE.
- WRITE: mem_address=dst_ptr, mem_we=1, mem_data_in = buffer (copy) or fill_value (fill). The memory commits at this edge. At the edge: dst_ptr+1, words_left−1.
  - If words_left was 1 → DONE.
  - Otherwise copy → READ, fill → stay in WRITE.
- DONE: done=1 for exactly one cycle, busy=0, mem_we=0 → IDLE.
- busy=1 only in READ/WRITE.
- words_left: loaded with the clamped count on the accepting edge; 0 in IDLE after completion.
- In IDLE/DONE: mem_address=0, mem_data_in=0, mem_we=0. All memory-side outputs are decoded from registered state only (no input-to-output combinational path except via mem_data_out into the buffer register).
- Pointers wrap modulo 2**ADDR_WIDTH (0x3FF+1 = 0x000).
- Timing: copy of N words occupies 2N busy cycles; fill occupies N. done is asserted in the cycle after the last write.
- start while busy or in DONE is ignored; no queuing.
- Overlapping regions: strictly ascending word-by-word semantics. Each read observes all earlier writes of the same operation; no overlap correction.
- mem_we is never asserted in READ, IDLE or DONE.

Test Plan:
- Copy: preload mem[0x010..0x013]=0x1111,0x2222,0x3333,0x4444; start mode=0 src=0x010 dst=0x200 len=4.
  - busy high 8 cycles, done pulse 1 cycle.
  - mem[0x200..0x203] equals the source; source unchanged; words_left 4→0.
- Fill: mode=1 dst=0x050 len=3 fill=0xBEEF.
  - mem_we high exactly 3 consecutive cycles; mem[0x050..0x052]=0xBEEF; mem[0x053] unchanged.
- Zero length / wrap:
  - len=0: no mem_we, done pulses the cycle after start, busy stays 0.
  - Fill dst=0x3FE len=4 val=0x00AA: writes 0x3FE,0x3FF,0x000,0x001 in that order.
- Overlap: mem[0x100]=0xA5A5, mem[0x101..0x103]=0; copy src=0x100 dst=0x101 len=3 → mem[0x101..0x103]=0xA5A5.
- Abort and ignored start:
  - Start copy len=10; pulse start with different args during busy → ignored, original 10-word copy completes.
  - New copy: assert RST_N=0 after the 3rd write → busy, mem_we and words_left drop to 0 immediately; only 3 destination words modified.
- Clamp: fill len=0x7FF → exactly 1024 writes, every address written once, done once.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator for the single-port data memory. Copies a block of words
//   from src to dst (read, then write, one word at a time), or fills a block
//   with a constant. Blocks hold 0..2**ADDR_WIDTH words; larger requests are
//   clamped to a full memory. Pointers wrap around the top of memory.
//
// Ports
//   CLK, RST_N    clock (rising edge), asynchronous active-low reset
//   start         one-cycle request, only honoured in IDLE
//   mode          0 = copy, 1 = fill (sampled with start)
//   src_addr      copy source base (sampled with start)
//   dst_addr      destination base (sampled with start)
//   length        word count 0..2**ADDR_WIDTH (sampled with start)
//   fill_value    fill word (sampled with start)
//   busy          high while reading or writing
//   done          one-cycle completion pulse
//   words_left    words not yet written
//   mem_address   memory address
//   mem_we        memory write enable
//   mem_data_in   memory write data
//   mem_data_out  combinational read data for mem_address
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; memory port parked at zero
// S_READ  | copy only: present src_ptr, capture read data into buffer
// S_WRITE | present dst_ptr with write data, memory commits at edge
// S_DONE  | one-cycle done pulse, then back to idle
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_left,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_src_ptr;
  logic [ADDR_WIDTH-1:0] r_dst_ptr;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [ADDR_WIDTH:0]   r_words_left;

  logic [ADDR_WIDTH:0]   w_count;

  assign w_count = (length > MAX_COUNT) ? MAX_COUNT : length;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_fill       <= '0;
      r_buf        <= '0;
      r_words_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode       <= mode;
            r_src_ptr    <= src_addr;
            r_dst_ptr    <= dst_addr;
            r_fill       <= fill_value;
            r_words_left <= w_count;
            if (w_count == '0)
              r_state <= S_DONE;
            else if (mode)
              r_state <= S_WRITE;
            else
              r_state <= S_READ;
          end
        end
        S_READ: begin
          r_buf     <= mem_data_out;
          r_src_ptr <= r_src_ptr + ADDR_WIDTH'(1);
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          r_dst_ptr    <= r_dst_ptr + ADDR_WIDTH'(1);
          r_words_left <= r_words_left - (ADDR_WIDTH+1)'(1);
          if (r_words_left == (ADDR_WIDTH+1)'(1))
            r_state <= S_DONE;
          else if (r_mode)
            r_state <= S_WRITE;
          else
            r_state <= S_READ;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs come only from registered state so the port has
  // no combinational dependence on the request inputs.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (r_state)
      S_READ: begin
        busy        = 1'b1;
        mem_address = r_src_ptr;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        mem_address = r_dst_ptr;
        mem_data_in = r_mode ? r_fill : r_buf;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign words_left = r_words_left;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        mode;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] length;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [10:0] words_left;
  logic [9:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  mem_copy_engine #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .fill_value   (fill_value),
    .busy         (busy),
    .done         (done),
    .words_left   (words_left),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model plus backdoor preload port.
  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge CLK) begin
    if (bd_we)       mem[bd_addr]     <= bd_data;
    else if (mem_we) mem[mem_address] <= mem_data_in;
  end

  assign mem_data_out = mem[mem_address];

  int n_checks = 0;
  int n_fail   = 0;

  int busy_cnt, done_cnt, we_cnt, bad_we, bad_idle;
  logic [9:0] wr_q[$];

  always @(negedge CLK) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_we) begin
      we_cnt++;
      wr_q.push_back(mem_address);
    end
    if (mem_we && !busy) bad_we++;
    if (!busy && (mem_address != 10'd0 || mem_data_in != 16'd0)) bad_idle++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [15:0] d);
    @(negedge CLK);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(negedge CLK);
    bd_we = 1'b0;
  endtask

  function automatic int mem_diffs();
    int k = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== ref_mem[i]) k++;
    return k;
  endfunction

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; we_cnt = 0; bad_we = 0; bad_idle = 0;
    wr_q.delete();
  endtask

  task automatic scramble_args();
    mode       = 1'($urandom);
    src_addr   = 10'($urandom);
    dst_addr   = 10'($urandom);
    length     = 11'($urandom);
    fill_value = 16'($urandom);
  endtask

  // Reference: ascending word-by-word copy/fill on an array, expected
  // write address list, and cycle costs from the timing rules.
  task automatic run_op(input string tag, input logic m, input logic [9:0] s,
                        input logic [9:0] d, input logic [10:0] len,
                        input logic [15:0] fv, input int poke);
    int n, cyc, ord_err;
    logic [9:0] exp_addr[$];
    logic [9:0] a;
    n = (len > 11'd1024) ? 1024 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = 10'(d + i);
      exp_addr.push_back(a);
      ref_mem[a] = m ? fv : ref_mem[10'(s + i)];
    end
    clear_mon();
    @(negedge CLK);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    @(negedge CLK);
    start = 1'b0;
    scramble_args();
    chk({tag, ":wl_load"}, 32'(words_left), 32'(n));
    chk({tag, ":busy_first"}, 32'(busy), 32'(n != 0));
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
      if (poke >= 0) begin
        start = (cyc == poke);
        if (cyc == poke) scramble_args();
      end
    end
    start = 1'b0;
    chk({tag, ":done_seen"}, 32'(done), 32'd1);
    chk({tag, ":done_lat"}, 32'(cyc), 32'(m ? n : 2 * n));
    @(negedge CLK);
    chk({tag, ":done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ":wl_end"}, 32'(words_left), 32'd0);
    chk({tag, ":busy_end"}, 32'(busy), 32'd0);
    chk({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(m ? n : 2 * n));
    chk({tag, ":we_cycles"}, 32'(we_cnt), 32'(n));
    chk({tag, ":done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ":we_outside"}, 32'(bad_we), 32'd0);
    chk({tag, ":idle_port"}, 32'(bad_idle), 32'd0);
    ord_err = 0;
    for (int i = 0; i < n && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_addr[i]) ord_err++;
    chk({tag, ":wr_order"}, 32'(ord_err), 32'd0);
    chk({tag, ":mem"}, 32'(mem_diffs()), 32'd0);
  endtask

  task automatic abort_test();
    int k, cyc;
    for (int i = 0; i < 3; i++)
      ref_mem[10'(10'h320 + i)] = ref_mem[10'(10'h300 + i)];
    clear_mon();
    @(negedge CLK);
    start = 1'b1; mode = 1'b0; src_addr = 10'h300; dst_addr = 10'h320;
    length = 11'd8; fill_value = 16'h0;
    @(negedge CLK);
    start = 1'b0;
    k = 0; cyc = 0;
    while (cyc < 100) begin
      if (mem_we) k++;
      if (k == 3) break;
      @(negedge CLK);
      cyc++;
    end
    chk("abort:reach3", 32'(k), 32'd3);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:we", 32'(mem_we), 32'd0);
    chk("abort:wl", 32'(words_left), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort:we_cnt", 32'(we_cnt), 32'd3);
    chk("abort:done_cnt", 32'(done_cnt), 32'd0);
    chk("abort:mem", 32'(mem_diffs()), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    mode = 1'b0; src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    clear_mon();
    for (int i = 0; i < 1024; i++) bd_write(10'(i), 16'($urandom));

    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:wl", 32'(words_left), 32'd0);
    chk("rst:we", 32'(mem_we), 32'd0);
    chk("rst:addr", 32'(mem_address), 32'd0);
    chk("rst:wdata", 32'(mem_data_in), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    bd_write(10'h010, 16'h1111);
    bd_write(10'h011, 16'h2222);
    bd_write(10'h012, 16'h3333);
    bd_write(10'h013, 16'h4444);
    run_op("copy4", 1'b0, 10'h010, 10'h200, 11'd4, 16'h0, -1);
    chk("copy4:dst0", 32'(mem[10'h200]), 32'h1111);
    chk("copy4:dst3", 32'(mem[10'h203]), 32'h4444);

    run_op("fill3", 1'b1, 10'h0, 10'h050, 11'd3, 16'hBEEF, -1);
    chk("fill3:w52", 32'(mem[10'h052]), 32'hBEEF);

    run_op("zero", 1'b0, 10'h123, 10'h234, 11'd0, 16'h0, -1);
    run_op("wrap", 1'b1, 10'h0, 10'h3FE, 11'd4, 16'h00AA, -1);
    chk("wrap:w001", 32'(mem[10'h001]), 32'h00AA);

    bd_write(10'h100, 16'hA5A5);
    bd_write(10'h101, 16'h0);
    bd_write(10'h102, 16'h0);
    bd_write(10'h103, 16'h0);
    run_op("overlap", 1'b0, 10'h100, 10'h101, 11'd3, 16'h0, -1);
    chk("overlap:w103", 32'(mem[10'h103]), 32'hA5A5);

    run_op("ignore", 1'b0, 10'h120, 10'h140, 11'd10, 16'h0, 5);

    abort_test();

    run_op("clamp", 1'b1, 10'h0, 10'h155, 11'h7FF, 16'h5A5A, -1);

    for (int r = 0; r < 8; r++) begin
      logic [10:0] len;
      len = (r == 7) ? 11'($urandom_range(1000, 2047)) : 11'($urandom_range(0, 40));
      run_op($sformatf("rand%0d", r), 1'($urandom), 10'($urandom), 10'($urandom),
             len, 16'($urandom), (r % 2 == 1) ? 3 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
